// File: rtl/irq_pkg.sv
// Shared types and vector arithmetic for the interrupt responder.
// The IRQ_TIMEOUT_EN build option is used by interrupt_responder.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2,
        SERVICE = 2'd3
    } irq_state_e;

    localparam logic [15:0] VEC_BASE_DEF   = 16'h0100;
    localparam int          VEC_STRIDE_DEF = 4;

    function automatic logic [31:0] vec_addr(
        input logic [31:0] base,
        input logic [31:0] stride,
        input logic [31:0] id
    );
        return base + id * stride;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: lowest set request bit wins.
// Purely combinational.
module irq_priority_encoder #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0]         req_i,
    output logic                       valid_o,
    output logic [$clog2(NUM_SRC)-1:0] idx_o
);

    localparam int IDW = $clog2(NUM_SRC);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan downward so the lowest set index is written last.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDW'(i);
        end
    end

endmodule

// File: rtl/interrupt_responder.sv
// CPU-side interrupt responder: arbitrate, request, acknowledge, service.
// Define IRQ_TIMEOUT_EN to abandon requests left pending for TIMEOUT_CYC cycles.
module interrupt_responder
    import irq_pkg::*;
#(
    parameter int                NUM_SRC     = 8,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE    = ADDR_W'(VEC_BASE_DEF),
    parameter int                VEC_STRIDE  = VEC_STRIDE_DEF,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       gie,
    input  logic [NUM_SRC-1:0]         irq_req,
    output logic [NUM_SRC-1:0]         irq_ack,
    output logic                       cpu_irq,
    output logic [ADDR_W-1:0]          cpu_vec_addr,
    input  logic                       cpu_irq_take,
    input  logic                       cpu_reti,
    output logic                       in_service,
    output logic [$clog2(NUM_SRC)-1:0] active_id,
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NUM_SRC);

    if (NUM_SRC < 2 || NUM_SRC > 32 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("interrupt_responder: unsupported parameter set");
    end

    irq_state_e     state_q, state_d;
    logic [IDW-1:0] id_q, id_d;
    logic           pe_valid;
    logic [IDW-1:0] pe_idx;
    logic           tmo_hit;

    irq_priority_encoder #(
        .NUM_SRC (NUM_SRC)
    ) u_pe (
        .req_i   (irq_req & {NUM_SRC{gie}}),
        .valid_o (pe_valid),
        .idx_o   (pe_idx)
    );

`ifdef IRQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    assign tmo_hit = (cnt_q + CW'(1)) == CW'(TIMEOUT_CYC);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != PENDING) begin
            cnt_d = '0;
        end else if (!cpu_irq_take) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Pulse only when the timeout is the reason PENDING is left.
    assign tmo_d = (state_q == PENDING) && tmo_hit && !cpu_irq_take
                   && gie && irq_req[id_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (pe_valid) begin
                    id_d    = pe_idx;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (cpu_irq_take)        state_d = ACK;
                else if (!gie)           state_d = IDLE;
                else if (!irq_req[id_q]) state_d = IDLE;
                else if (tmo_hit)        state_d = IDLE;
            end
            ACK:     state_d = SERVICE;
            SERVICE: if (cpu_reti) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        irq_ack = '0;
        if (state_q == ACK) irq_ack[id_q] = 1'b1;
    end

    assign cpu_irq    = (state_q == PENDING);
    assign in_service = (state_q == ACK) || (state_q == SERVICE);
    assign active_id  = id_q;

    assign cpu_vec_addr = (state_q == IDLE) ? '0 :
        ADDR_W'(vec_addr(32'(VEC_BASE), 32'(VEC_STRIDE), 32'(id_q)));

endmodule

// File: tb/tb_interrupt_responder.sv
// Randomized bench for interrupt_responder against a behavioural model.
// Define IRQ_TIMEOUT_EN to also model the pending timeout (TIMEOUT_CYC=4).
module tb_interrupt_responder;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gie = 1'b0;
    logic [7:0]  irq_req = '0;
    logic        cpu_irq_take = 1'b0;
    logic        cpu_reti = 1'b0;
    logic [7:0]  irq_ack;
    logic        cpu_irq;
    logic [15:0] cpu_vec_addr;
    logic        in_service;
    logic [2:0]  active_id;
    logic        timeout_err;

    int vectors = 0;
    int miscompares = 0;

    bit m_pend, m_ack, m_svc, m_pulse;
    int m_id, m_wait;

    interrupt_responder #(
        .NUM_SRC     (8),
        .ADDR_W      (16),
        .VEC_BASE    (16'h0100),
        .VEC_STRIDE  (4),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gie          (gie),
        .irq_req      (irq_req),
        .irq_ack      (irq_ack),
        .cpu_irq      (cpu_irq),
        .cpu_vec_addr (cpu_vec_addr),
        .cpu_irq_take (cpu_irq_take),
        .cpu_reti     (cpu_reti),
        .in_service   (in_service),
        .active_id    (active_id),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [7:0] r);
        for (int i = 0; i < 8; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_ack = 0; m_svc = 0; m_pulse = 0;
        m_id = 0; m_wait = 0;
    endtask

    task automatic model_clock();
        m_pulse = 0;
        if (m_ack) begin
            m_ack = 0;
            m_svc = 1;
        end else if (m_svc) begin
            if (cpu_reti) m_svc = 0;
        end else if (m_pend) begin
            if (cpu_irq_take) begin
                m_pend = 0;
                m_ack  = 1;
            end else if (!gie || !irq_req[m_id]) begin
                m_pend = 0;
            end else begin
                m_wait++;
`ifdef IRQ_TIMEOUT_EN
                if (m_wait == TMO) begin
                    m_pend  = 0;
                    m_pulse = 1;
                end
`endif
            end
        end else if (gie && irq_req != 8'h00) begin
            m_id   = lowest(irq_req);
            m_pend = 1;
            m_wait = 0;
        end
    endtask

    task automatic check_outputs();
        logic [7:0]  eack;
        logic [15:0] evec;
        eack = '0;
        evec = '0;
        if (m_ack) eack[m_id] = 1'b1;
        if (m_pend || m_ack || m_svc) evec = 16'h0100 + 16'(m_id * 4);
        chk("cpu_irq", 32'(cpu_irq), 32'(m_pend));
        chk("irq_ack", 32'(irq_ack), 32'(eack));
        chk("in_service", 32'(in_service), 32'(m_ack || m_svc));
        chk("cpu_vec_addr", 32'(cpu_vec_addr), 32'(evec));
        chk("active_id", 32'(active_id), 32'(m_id));
        chk("timeout_err", 32'(timeout_err), 32'(m_pulse));
    endtask

    task automatic step(input bit g, input logic [7:0] r,
                        input bit tk, input bit rt);
        gie = g;
        irq_req = r;
        cpu_irq_take = tk;
        cpu_reti = rt;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_cpu_irq", 32'(cpu_irq), 32'd0);
        chk("rst_irq_ack", 32'(irq_ack), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_vec", 32'(cpu_vec_addr), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        logic [7:0] r;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Single source: request, take, ack, service, return.
        step(1, 8'h20, 0, 0);
        chk("t1_vec", 32'(cpu_vec_addr), 32'h0114);
        step(1, 8'h20, 1, 0);
        chk("t1_ack", 32'(irq_ack), 32'h20);
        step(1, 8'h00, 0, 0);
        step(1, 8'h00, 0, 1);

        // Two sources, lower index first, then the other after a gap.
        step(1, 8'h84, 0, 0);
        step(1, 8'h84, 1, 0);
        step(1, 8'h84, 0, 0);
        step(1, 8'h80, 0, 1);
        step(1, 8'h80, 0, 0);
        chk("t2_vec", 32'(cpu_vec_addr), 32'h011C);
        step(1, 8'h80, 1, 0);
        step(1, 8'h00, 0, 0);
        step(1, 8'h00, 0, 1);

        // Global enable masking and drop while pending.
        step(0, 8'hFF, 0, 0);
        step(0, 8'hFF, 0, 0);
        step(1, 8'hFF, 0, 0);
        step(0, 8'hFF, 0, 0);
        step(0, 8'h00, 0, 0);

        // Withdraw without take, then take coinciding with withdraw.
        step(1, 8'h08, 0, 0);
        step(1, 8'h00, 0, 0);
        step(1, 8'h08, 0, 0);
        step(1, 8'h00, 1, 0);
        step(1, 8'h00, 0, 0);
        step(1, 8'h00, 0, 1);

        // Reset during ACK and during SERVICE.
        step(1, 8'h08, 0, 0);
        step(1, 8'h08, 1, 0);
        do_reset();
        step(0, 8'h00, 0, 0);
        step(1, 8'h08, 0, 0);
        step(1, 8'h08, 1, 0);
        step(1, 8'h08, 0, 0);
        do_reset();
        step(1, 8'h00, 0, 0);

        // Timeout scenario: no take, then take on the terminal cycle.
        repeat (6) step(1, 8'h02, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h02, 1, 0);
        step(1, 8'h00, 0, 0);
        step(1, 8'h00, 0, 1);

        r = '0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(3) == 0) r = 8'($urandom) & 8'($urandom);
                step($urandom_range(9) != 0, r,
                     $urandom_range(3) == 0, $urandom_range(3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
